// File: rtl/gray_pkg.sv
// Shared types for the gray-to-binary decode path.
package gray_pkg;

   localparam int GRAY_W = 8;

   typedef logic [GRAY_W-1:0] gray_t;
   typedef logic [GRAY_W-1:0] bin_t;

endpackage : gray_pkg

// File: rtl/gray_decode_arbiter_g2b.sv
// Combinational gray-to-binary converter.
// Each binary bit is the XOR of all gray bits at or above it.
module gray_to_binary
   import gray_pkg::*;
(
   input  gray_t gray,
   output bin_t  binary
);

   always_comb begin
      binary = '0;
      binary[GRAY_W-1] = gray[GRAY_W-1];
      for (int i = GRAY_W - 2; i >= 0; i--) begin
         binary[i] = binary[i+1] ^ gray[i];
      end
   end

endmodule : gray_to_binary

// File: rtl/gray_decode_arbiter_rr.sv
// Combinational round-robin arbiter.
// The search starts one past ptr and wraps; the pointer register lives in the parent.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] winner,
   output logic                 any
);

   localparam int IW = $clog2(N);

   // One extra bit so ptr + k never overflows before the modulo-N wrap.
   logic [IW:0]   sum;
   logic [IW-1:0] idx;

   always_comb begin
      grant  = '0;
      winner = '0;
      any    = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         idx = sum[IW-1:0];
         if (!any && req[idx]) begin
            any         = 1'b1;
            grant[idx]  = 1'b1;
            winner      = idx;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/gray_decode_arbiter.sv
// Round-robin shared gray-to-binary converter with a single registered
// output stage carrying the result and the granted requester's ID.
module gray_decode_arbiter
   import gray_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int ID_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*GRAY_W-1:0] req_gray,
   output logic                      out_valid,
   input  logic                      out_ready,
   output bin_t                      out_binary,
   output logic [ID_W-1:0]           out_id
);

   logic [ID_W-1:0]    ptr;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    winner;
   logic               any_req;
   logic               accept_en;
   logic               xfer;
   gray_t              gray_sel;
   bin_t               bin_sel;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr),
      .grant  (grant),
      .winner (winner),
      .any    (any_req)
   );

   // The stage can take a new word when empty or being drained this cycle.
   assign accept_en = !rst && (!out_valid || out_ready);
   assign req_ready = grant & {NUM_REQ{accept_en}};
   assign xfer      = accept_en && any_req;

   assign gray_sel = req_gray[winner*GRAY_W +: GRAY_W];

   gray_to_binary u_g2b (
      .gray   (gray_sel),
      .binary (bin_sel)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_binary <= '0;
         out_id     <= '0;
         ptr        <= ID_W'(NUM_REQ - 1);
      end else if (xfer) begin
         out_valid  <= 1'b1;
         out_binary <= bin_sel;
         out_id     <= winner;
         ptr        <= winner;
      end else if (out_valid && out_ready) begin
         // Drained with nothing to replace it: data lines keep the last result.
         out_valid  <= 1'b0;
      end
   end

endmodule : gray_decode_arbiter

// File: tb/tb_gray_decode_arbiter.sv
// Directed scoreboard bench for gray_decode_arbiter with NUM_REQ = 4.
module tb_gray_decode_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_gray;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_binary;
   logic [1:0]  out_id;

   gray_decode_arbiter #(.NUM_REQ(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_gray   (req_gray),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_binary (out_binary),
      .out_id     (out_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] id;
      logic [7:0] bin;
   } exp_t;

   exp_t sb[$];
   exp_t m_last;
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;
   int   m_ptr  = 3;
   bit   m_valid = 1'b0;
   bit   m_known = 1'b0;
   bit   m_zero  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] v, input int ptr);
      for (int k = 1; k <= 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   function automatic logic [7:0] g2b(input logic [7:0] g);
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   // Compare the DUT against the model for this cycle, then advance one clock.
   task automatic step();
      logic [3:0] exp_rdy;
      int         w;
      bit         acc;
      exp_t       e;
      #1;
      acc     = !rst && (!m_valid || out_ready);
      w       = rr_pick(req_valid, m_ptr);
      exp_rdy = (acc && w >= 0) ? 4'(1 << w) : 4'b0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (m_known) begin
         chk("out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            if (sb.size() == 0) chk("scoreboard_empty", 32'(sb.size()), 32'd1);
            else begin
               chk("out_binary", 32'(out_binary), 32'(sb[0].bin));
               chk("out_id", 32'(out_id), 32'(sb[0].id));
            end
         end else if (m_zero) begin
            chk("rst_binary", 32'(out_binary), 32'd0);
            chk("rst_id", 32'(out_id), 32'd0);
         end else begin
            chk("hold_binary", 32'(out_binary), 32'(m_last.bin));
            chk("hold_id", 32'(out_id), 32'(m_last.id));
         end
      end
      if (rst) begin
         sb.delete();
         m_valid = 1'b0;
         m_ptr   = 3;
         m_zero  = 1'b1;
         m_known = 1'b1;
      end else if (acc && w >= 0) begin
         if (m_valid) void'(sb.pop_front());
         e.id  = 2'(w);
         e.bin = g2b(req_gray[w*8 +: 8]);
         sb.push_back(e);
         m_last  = e;
         m_ptr   = w;
         m_valid = 1'b1;
         m_zero  = 1'b0;
      end else if (m_valid && out_ready) begin
         void'(sb.pop_front());
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   logic [7:0] t3_in  [5];
   logic [7:0] t3_exp [5];

   initial begin
      t3_in  = '{8'h00, 8'h01, 8'h03, 8'hC0, 8'hFF};
      t3_exp = '{8'h00, 8'h01, 8'h02, 8'h80, 8'hAA};

      // 1: reset with all requesters valid
      rst = 1'b1; req_valid = 4'hF; out_ready = 1'b1;
      req_gray = 32'h11_22_33_44;
      step();
      step();

      // 2: single requester 2 with gray 80
      rst = 1'b0; req_valid = 4'b0100; req_gray = 32'h00_80_00_00;
      #1 chk("t2_ready", 32'(req_ready), 32'h4);
      step();
      req_valid = 4'b0000;
      #1;
      chk("t2_valid", 32'(out_valid), 32'd1);
      chk("t2_binary", 32'(out_binary), 32'hFF);
      chk("t2_id", 32'(out_id), 32'd2);
      step();
      step();

      // 3: successive words from one requester, back to back
      for (int k = 0; k <= 5; k++) begin
         req_valid = (k < 5) ? 4'b0001 : 4'b0000;
         req_gray  = (k < 5) ? {24'h0, t3_in[k]} : 32'h0;
         #1;
         if (k > 0) chk("t3_binary", 32'(out_binary), 32'(t3_exp[k-1]));
         step();
      end

      // 4: all valid after reset -> strict rotation from requester 0
      rst = 1'b1; req_valid = 4'h0;
      step();
      rst = 1'b0; req_valid = 4'hF; req_gray = 32'hC0_03_01_FF;
      for (int k = 0; k < 8; k++) begin
         #1 chk("t4_rotate", 32'(req_ready), 32'(1 << (k % 4)));
         step();
      end

      // 5: stall for three cycles, then release
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t5_stall_ready", 32'(req_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1 chk("t5_release_accept", 32'(req_ready), 32'h1);
      step();
      req_valid = 4'h0;
      step();
      step();

      // 6: reset while a result is held and requesters 1 and 3 are pending
      out_ready = 1'b0; req_valid = 4'b1010; req_gray = 32'h40_00_07_00;
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("t6_valid_cleared", 32'(out_valid), 32'd0);
      chk("t6_first_grant", 32'(req_ready), 32'h2);
      step();
      req_valid = 4'b1000;
      #1 chk("t6_second_grant", 32'(req_ready), 32'h8);
      step();
      req_valid = 4'b0000;
      step();
      step();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule : tb_gray_decode_arbiter
